// File: rtl/dma_pkg.sv
// Shared types for the DMA read path: AXI burst encodings, the read-bridge
// state machine states and the fixed response code.
package dma_pkg;

    typedef enum logic [1:0] {
        FIXED = 2'd0,
        INCR  = 2'd1,
        WRAP  = 2'd2
    } burst_e;

    typedef enum logic {
        IDLE  = 1'b0,
        BURST = 1'b1
    } rd_state_e;

    localparam logic [1:0] RESP_OKAY = 2'b00;

endpackage

// File: rtl/rd_ret_fifo.sv
// Two-entry synchronous FIFO holding returned read beats until the AXI master
// accepts them; push and pop may happen in the same cycle.
module rd_ret_fifo #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic [1:0]       occ,
    output logic             empty
);

    logic [WIDTH-1:0] mem_q [2];
    logic [WIDTH-1:0] mem_d [2];
    logic             wr_ptr_q, wr_ptr_d;
    logic             rd_ptr_q, rd_ptr_d;
    logic [1:0]       occ_q, occ_d;
    logic             push_ok;
    logic             pop_ok;

    assign pop_ok  = pop && (occ_q != 2'd0);
    assign push_ok = push && ((occ_q != 2'd2) || pop_ok);

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        occ_d    = occ_q;
        if (push_ok) begin
            mem_d[wr_ptr_q] = din;
            wr_ptr_d        = ~wr_ptr_q;
        end
        if (pop_ok) begin
            rd_ptr_d = ~rd_ptr_q;
        end
        case ({push_ok, pop_ok})
            2'b10:   occ_d = occ_q + 2'd1;
            2'b01:   occ_d = occ_q - 2'd1;
            default: occ_d = occ_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            mem_q[0] <= '0;
            mem_q[1] <= '0;
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            occ_q    <= 2'd0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            occ_q    <= occ_d;
        end
    end

    assign dout  = mem_q[rd_ptr_q];
    assign occ   = occ_q;
    assign empty = (occ_q == 2'd0);

endmodule

// File: rtl/axi_rd_ram_bridge.sv
// AXI4 read slave that turns AR bursts into single-word reads on a 1-cycle
// latency RAM port and streams the results back as R beats.
module axi_rd_ram_bridge
    import dma_pkg::*;
#(
    parameter int AXI_WIDTH      = 128,
    parameter int AXI_ADDR_WIDTH = 32,
    parameter int AXI_ID_WIDTH   = 6
) (
    input  logic                                          clk,
    input  logic                                          rst,
    input  logic [AXI_ID_WIDTH-1:0]                       s_axi_arid,
    input  logic [AXI_ADDR_WIDTH-1:0]                     s_axi_araddr,
    input  logic [7:0]                                    s_axi_arlen,
    input  logic [2:0]                                    s_axi_arsize,
    input  logic [1:0]                                    s_axi_arburst,
    input  logic                                          s_axi_arvalid,
    output logic                                          s_axi_arready,
    output logic [AXI_ID_WIDTH-1:0]                       s_axi_rid,
    output logic [AXI_WIDTH-1:0]                          s_axi_rdata,
    output logic [1:0]                                    s_axi_rresp,
    output logic                                          s_axi_rlast,
    output logic                                          s_axi_rvalid,
    input  logic                                          s_axi_rready,
    output logic                                          mm2s_ren,
    output logic [AXI_ADDR_WIDTH-($clog2(AXI_WIDTH)-3)-1:0] mm2s_addr,
    input  logic [AXI_WIDTH-1:0]                          mm2s_data
);

    localparam int LSB     = $clog2(AXI_WIDTH) - 3;
    localparam int WADDR_W = AXI_ADDR_WIDTH - LSB;
    localparam int ENTRY_W = AXI_WIDTH + AXI_ID_WIDTH + 1;

    rd_state_e                 state_q, state_d;
    logic [WADDR_W-1:0]        addr_q, addr_d;
    logic [8:0]                remaining_q, remaining_d;
    logic [AXI_ID_WIDTH-1:0]   id_q, id_d;
    burst_e                    burst_q, burst_d;
    logic                      alive_q, alive_d;
    logic                      inflight_q, inflight_d;
    logic                      inflight_last_q, inflight_last_d;
    logic [AXI_ID_WIDTH-1:0]   inflight_id_q, inflight_id_d;

    logic                      ar_fire;
    logic                      ren;
    logic                      pop;
    logic [2:0]                pending;
    logic [1:0]                fifo_occ;
    logic                      fifo_empty;
    logic [ENTRY_W-1:0]        push_entry;
    logic [ENTRY_W-1:0]        head_entry;
    logic                      unused_ok;

    assign unused_ok = ^{s_axi_arsize, s_axi_araddr[LSB-1:0]};

    // Reads are only issued while the FIFO can still take every beat already
    // committed, counting the slot freed by a pop this cycle.
    assign pop     = s_axi_rvalid && s_axi_rready;
    assign pending = {1'b0, fifo_occ} + {2'b00, inflight_q} - {2'b00, pop};
    assign ren     = (state_q == BURST) && (pending < 3'd2);
    assign ar_fire = s_axi_arvalid && s_axi_arready;

    always_comb begin
        state_d         = state_q;
        addr_d          = addr_q;
        remaining_d     = remaining_q;
        id_d            = id_q;
        burst_d         = burst_q;
        alive_d         = 1'b1;
        inflight_d      = ren;
        inflight_last_d = ren && (remaining_q == 9'd1);
        inflight_id_d   = id_q;
        case (state_q)
            IDLE: begin
                if (ar_fire) begin
                    addr_d      = s_axi_araddr[AXI_ADDR_WIDTH-1:LSB];
                    remaining_d = {1'b0, s_axi_arlen} + 9'd1;
                    id_d        = s_axi_arid;
                    burst_d     = burst_e'(s_axi_arburst);
                    state_d     = BURST;
                end
            end
            BURST: begin
                if (ren) begin
                    remaining_d = remaining_q - 9'd1;
                    if (burst_q != FIXED) begin
                        addr_d = addr_q + WADDR_W'(1);
                    end
                    if (remaining_q == 9'd1) begin
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q         <= IDLE;
            addr_q          <= '0;
            remaining_q     <= 9'd0;
            id_q            <= '0;
            burst_q         <= FIXED;
            alive_q         <= 1'b0;
            inflight_q      <= 1'b0;
            inflight_last_q <= 1'b0;
            inflight_id_q   <= '0;
        end else begin
            state_q         <= state_d;
            addr_q          <= addr_d;
            remaining_q     <= remaining_d;
            id_q            <= id_d;
            burst_q         <= burst_d;
            alive_q         <= alive_d;
            inflight_q      <= inflight_d;
            inflight_last_q <= inflight_last_d;
            inflight_id_q   <= inflight_id_d;
        end
    end

    // Each entry carries its own id and last flag so the next burst may start
    // issuing while earlier beats are still queued.
    assign push_entry = {mm2s_data, inflight_id_q, inflight_last_q};

    rd_ret_fifo #(
        .WIDTH(ENTRY_W)
    ) u_ret_fifo (
        .clk  (clk),
        .rst  (rst),
        .push (inflight_q),
        .pop  (pop),
        .din  (push_entry),
        .dout (head_entry),
        .occ  (fifo_occ),
        .empty(fifo_empty)
    );

    assign s_axi_arready = (state_q == IDLE) && alive_q;
    assign s_axi_rvalid  = !fifo_empty;
    assign s_axi_rdata   = head_entry[ENTRY_W-1 -: AXI_WIDTH];
    assign s_axi_rid     = head_entry[AXI_ID_WIDTH:1];
    assign s_axi_rlast   = head_entry[0];
    assign s_axi_rresp   = RESP_OKAY;
    assign mm2s_ren      = ren;
    assign mm2s_addr     = addr_q;

endmodule

// File: tb/tb_axi_rd_ram_bridge.sv
// Directed self-checking bench for axi_rd_ram_bridge with a 1-cycle RAM model
// and a negedge monitor that logs issued reads and accepted R beats.
module tb_axi_rd_ram_bridge;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic [5:0]   s_axi_arid = '0;
    logic [31:0]  s_axi_araddr = '0;
    logic [7:0]   s_axi_arlen = '0;
    logic [2:0]   s_axi_arsize = 3'd4;
    logic [1:0]   s_axi_arburst = 2'd1;
    logic         s_axi_arvalid = 1'b0;
    logic         s_axi_arready;
    logic [5:0]   s_axi_rid;
    logic [127:0] s_axi_rdata;
    logic [1:0]   s_axi_rresp;
    logic         s_axi_rlast;
    logic         s_axi_rvalid;
    logic         s_axi_rready = 1'b1;
    logic         mm2s_ren;
    logic [27:0]  mm2s_addr;
    logic [127:0] mm2s_data = '0;

    int checks = 0;
    int errors = 0;
    int cycle  = 0;

    logic [27:0]  ren_addr_q[$];
    int           ren_cyc_q[$];
    logic [127:0] r_data_q[$];
    logic [5:0]   r_id_q[$];
    logic         r_last_q[$];
    logic [1:0]   r_resp_q[$];
    int           r_cyc_q[$];
    int           outstanding = 0;
    int           max_outstanding = 0;
    int           stall_err = 0;
    logic         prev_stall = 1'b0;
    logic [127:0] prev_rdata = '0;
    logic [5:0]   prev_rid = '0;
    logic         prev_rlast = 1'b0;

    axi_rd_ram_bridge dut (
        .clk          (clk),
        .rst          (rst),
        .s_axi_arid   (s_axi_arid),
        .s_axi_araddr (s_axi_araddr),
        .s_axi_arlen  (s_axi_arlen),
        .s_axi_arsize (s_axi_arsize),
        .s_axi_arburst(s_axi_arburst),
        .s_axi_arvalid(s_axi_arvalid),
        .s_axi_arready(s_axi_arready),
        .s_axi_rid    (s_axi_rid),
        .s_axi_rdata  (s_axi_rdata),
        .s_axi_rresp  (s_axi_rresp),
        .s_axi_rlast  (s_axi_rlast),
        .s_axi_rvalid (s_axi_rvalid),
        .s_axi_rready (s_axi_rready),
        .mm2s_ren     (mm2s_ren),
        .mm2s_addr    (mm2s_addr),
        .mm2s_data    (mm2s_data)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cycle <= cycle + 1;

    function automatic logic [127:0] pat(input logic [27:0] a);
        logic [31:0] w;
        w = {4'h0, a};
        return {w ^ 32'hDEAD_BEEF, ~w, w + 32'h1234_5678, w};
    endfunction

    // RAM model: data for the word read in one cycle appears in the next.
    always @(posedge clk) begin
        if (mm2s_ren) mm2s_data <= pat(mm2s_addr);
    end

    always @(negedge clk) begin
        if (rst) begin
            outstanding = 0;
            prev_stall  = 1'b0;
        end else begin
            if (mm2s_ren) begin
                ren_addr_q.push_back(mm2s_addr);
                ren_cyc_q.push_back(cycle);
            end
            if (s_axi_rvalid && s_axi_rready) begin
                r_data_q.push_back(s_axi_rdata);
                r_id_q.push_back(s_axi_rid);
                r_last_q.push_back(s_axi_rlast);
                r_resp_q.push_back(s_axi_rresp);
                r_cyc_q.push_back(cycle);
            end
            if (prev_stall && (!s_axi_rvalid || s_axi_rdata !== prev_rdata ||
                               s_axi_rid !== prev_rid || s_axi_rlast !== prev_rlast))
                stall_err++;
            prev_stall  = s_axi_rvalid && !s_axi_rready;
            prev_rdata  = s_axi_rdata;
            prev_rid    = s_axi_rid;
            prev_rlast  = s_axi_rlast;
            outstanding = outstanding + int'(mm2s_ren) - int'(s_axi_rvalid && s_axi_rready);
            if (outstanding > max_outstanding) max_outstanding = outstanding;
        end
    end

    task automatic clear_logs();
        ren_addr_q.delete();
        ren_cyc_q.delete();
        r_data_q.delete();
        r_id_q.delete();
        r_last_q.delete();
        r_resp_q.delete();
        r_cyc_q.delete();
        max_outstanding = 0;
        stall_err = 0;
    endtask

    // Returns the cycle number of the AR handshake; leaves time at posedge+1 of the next cycle.
    task automatic send_ar(input logic [5:0] id, input logic [31:0] addr, input logic [7:0] len,
                           input logic [1:0] burst, output int t);
        int n;
        @(posedge clk);
        #1;
        s_axi_arid    = id;
        s_axi_araddr  = addr;
        s_axi_arlen   = len;
        s_axi_arburst = burst;
        s_axi_arvalid = 1'b1;
        n = 0;
        @(negedge clk);
        while (!s_axi_arready && n < 100) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (s_axi_arready !== 1'b1) begin
            errors++;
            $display("[TB] FAIL ar_handshake_timeout: arready got %b required 1", s_axi_arready);
        end
        t = cycle;
        @(posedge clk);
        #1;
        s_axi_arvalid = 1'b0;
    endtask

    task automatic wait_beats(input int n, input string name);
        int budget;
        budget = 0;
        while (r_data_q.size() < n && budget < 300) begin
            @(negedge clk);
            budget++;
        end
        repeat (4) @(negedge clk);
        checks++;
        if (r_data_q.size() != n) begin
            errors++;
            $display("[TB] FAIL %s_beat_count: got %0d required %0d", name, r_data_q.size(), n);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks++;
        if ({s_axi_arready, s_axi_rvalid, s_axi_rlast, mm2s_ren} !== 4'b0000) begin
            errors++;
            $display("[TB] FAIL reset_ctrl: arready/rvalid/rlast/ren got %b required 0000",
                     {s_axi_arready, s_axi_rvalid, s_axi_rlast, mm2s_ren});
        end
        checks++;
        if (s_axi_rdata !== 128'd0 || s_axi_rid !== 6'd0 || s_axi_rresp !== 2'd0 || mm2s_addr !== 28'd0) begin
            errors++;
            $display("[TB] FAIL reset_data: rdata %h rid %h rresp %h addr %h required all zero",
                     s_axi_rdata, s_axi_rid, s_axi_rresp, mm2s_addr);
        end
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(posedge clk);
        @(negedge clk);
        checks++;
        if (s_axi_arready !== 1'b1) begin
            errors++;
            $display("[TB] FAIL reset_release_arready: got %b required 1", s_axi_arready);
        end
    endtask

    task automatic test_single_beat();
        int t;
        clear_logs();
        s_axi_rready = 1'b1;
        send_ar(6'h2A, 32'h0000_0100, 8'd0, 2'd1, t);
        wait_beats(1, "single");
        checks++;
        if (ren_addr_q.size() != 1 || ren_addr_q[0] !== 28'h10 || ren_cyc_q[0] != t + 1) begin
            errors++;
            $display("[TB] FAIL single_ren: reads %0d addr %h cycle %0d required 1 read addr 10 cycle %0d",
                     ren_addr_q.size(), ren_addr_q[0], ren_cyc_q[0], t + 1);
        end
        checks++;
        if (r_cyc_q[0] != t + 3) begin
            errors++;
            $display("[TB] FAIL single_rvalid_latency: got cycle %0d required %0d", r_cyc_q[0], t + 3);
        end
        checks++;
        if (r_data_q[0] !== pat(28'h10) || r_id_q[0] !== 6'h2A || r_last_q[0] !== 1'b1 || r_resp_q[0] !== 2'b00) begin
            errors++;
            $display("[TB] FAIL single_beat: data %h id %h last %b resp %b required data %h id 2a last 1 resp 00",
                     r_data_q[0], r_id_q[0], r_last_q[0], r_resp_q[0], pat(28'h10));
        end
    endtask

    task automatic test_incr_full_rate();
        int t;
        clear_logs();
        s_axi_rready = 1'b1;
        send_ar(6'h03, 32'h0, 8'd15, 2'd1, t);
        wait_beats(16, "incr");
        checks++;
        if (ren_addr_q.size() != 16) begin
            errors++;
            $display("[TB] FAIL incr_read_count: got %0d required 16", ren_addr_q.size());
        end
        for (int i = 0; i < 16; i++) begin
            checks++;
            if (ren_addr_q[i] !== 28'(i) || ren_cyc_q[i] != t + 1 + i) begin
                errors++;
                $display("[TB] FAIL incr_ren[%0d]: addr %h cycle %0d required addr %h cycle %0d",
                         i, ren_addr_q[i], ren_cyc_q[i], 28'(i), t + 1 + i);
            end
            checks++;
            if (r_data_q[i] !== pat(28'(i)) || r_last_q[i] !== (i == 15) || r_cyc_q[i] != t + 3 + i) begin
                errors++;
                $display("[TB] FAIL incr_beat[%0d]: data %h last %b cycle %0d required data %h last %b cycle %0d",
                         i, r_data_q[i], r_last_q[i], r_cyc_q[i], pat(28'(i)), (i == 15), t + 3 + i);
            end
        end
    endtask

    task automatic test_backpressure();
        int t;
        int k;
        logic [3:0] rr_pat;
        clear_logs();
        rr_pat = 4'b1001;
        s_axi_rready = 1'b1;
        send_ar(6'h05, 32'h0000_0200, 8'd7, 2'd1, t);
        k = 0;
        while (r_data_q.size() < 8 && k < 300) begin
            s_axi_rready = rr_pat[k[1:0]];
            @(posedge clk);
            #1;
            k++;
        end
        s_axi_rready = 1'b1;
        wait_beats(8, "backpressure");
        checks++;
        if (ren_addr_q.size() != 8) begin
            errors++;
            $display("[TB] FAIL bp_read_count: got %0d required 8", ren_addr_q.size());
        end
        for (int i = 0; i < 8; i++) begin
            checks++;
            if (r_data_q[i] !== pat(28'h20 + 28'(i)) || r_id_q[i] !== 6'h05 || r_last_q[i] !== (i == 7)) begin
                errors++;
                $display("[TB] FAIL bp_beat[%0d]: data %h id %h last %b required data %h id 05 last %b",
                         i, r_data_q[i], r_id_q[i], r_last_q[i], pat(28'h20 + 28'(i)), (i == 7));
            end
        end
        checks++;
        if (max_outstanding > 2) begin
            errors++;
            $display("[TB] FAIL bp_outstanding: got %0d required at most 2", max_outstanding);
        end
        checks++;
        if (stall_err != 0) begin
            errors++;
            $display("[TB] FAIL bp_stall_stable: unstable stalled cycles %0d required 0", stall_err);
        end
    endtask

    task automatic test_fixed();
        int t;
        clear_logs();
        s_axi_rready = 1'b1;
        send_ar(6'h07, 32'h0000_0040, 8'd3, 2'd0, t);
        wait_beats(4, "fixed");
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (ren_addr_q[i] !== 28'h4 || r_data_q[i] !== pat(28'h4) || r_last_q[i] !== (i == 3)) begin
                errors++;
                $display("[TB] FAIL fixed_beat[%0d]: addr %h data %h last %b required addr 4 data %h last %b",
                         i, ren_addr_q[i], r_data_q[i], r_last_q[i], pat(28'h4), (i == 3));
            end
        end
    endtask

    task automatic test_wrap_back_to_back();
        int ta;
        int tb;
        logic [27:0] exp_addr [6];
        logic [5:0]  exp_id   [6];
        logic        exp_last [6];
        clear_logs();
        s_axi_rready = 1'b1;
        exp_addr = '{28'hFFFFFFE, 28'hFFFFFFF, 28'h0, 28'h1, 28'h30, 28'h31};
        exp_id   = '{6'd1, 6'd1, 6'd1, 6'd1, 6'd2, 6'd2};
        exp_last = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
        send_ar(6'd1, 32'hFFFF_FFE0, 8'd3, 2'd1, ta);
        send_ar(6'd2, 32'h0000_0300, 8'd1, 2'd1, tb);
        wait_beats(6, "b2b");
        checks++;
        if (tb != ta + 5 || ren_cyc_q[4] != ta + 6) begin
            errors++;
            $display("[TB] FAIL b2b_gap: B accepted %0d first read %0d required %0d and %0d",
                     tb, ren_cyc_q[4], ta + 5, ta + 6);
        end
        for (int i = 0; i < 6; i++) begin
            checks++;
            if (ren_addr_q[i] !== exp_addr[i] || r_data_q[i] !== pat(exp_addr[i]) ||
                r_id_q[i] !== exp_id[i] || r_last_q[i] !== exp_last[i]) begin
                errors++;
                $display("[TB] FAIL b2b_beat[%0d]: addr %h id %h last %b required addr %h id %h last %b",
                         i, ren_addr_q[i], r_id_q[i], r_last_q[i], exp_addr[i], exp_id[i], exp_last[i]);
            end
        end
    endtask

    task automatic test_reset_mid_burst();
        int t;
        clear_logs();
        s_axi_rready = 1'b1;
        send_ar(6'd9, 32'h0000_0500, 8'd7, 2'd1, t);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        clear_logs();
        @(negedge clk);
        checks++;
        if ({s_axi_rvalid, mm2s_ren, s_axi_arready} !== 3'b000 || s_axi_rdata !== 128'd0) begin
            errors++;
            $display("[TB] FAIL midrst_state: rvalid/ren/arready %b rdata %h required 000 and zero",
                     {s_axi_rvalid, mm2s_ren, s_axi_arready}, s_axi_rdata);
        end
        @(negedge clk);
        checks++;
        if (s_axi_arready !== 1'b1) begin
            errors++;
            $display("[TB] FAIL midrst_arready: got %b required 1", s_axi_arready);
        end
        send_ar(6'd11, 32'h0000_0600, 8'd2, 2'd1, t);
        wait_beats(3, "midrst_fresh");
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (r_data_q[i] !== pat(28'h60 + 28'(i)) || r_id_q[i] !== 6'd11 || r_last_q[i] !== (i == 2)) begin
                errors++;
                $display("[TB] FAIL midrst_beat[%0d]: data %h id %h last %b required data %h id 0b last %b",
                         i, r_data_q[i], r_id_q[i], r_last_q[i], pat(28'h60 + 28'(i)), (i == 2));
            end
        end
    endtask

    initial begin
        test_reset();
        test_single_beat();
        test_incr_full_rate();
        test_backpressure();
        test_fixed();
        test_wrap_back_to_back();
        test_reset_mid_burst();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
